// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted request takes two cycles: operand issue (GNT), then result capture (DONE).
module alu_arbiter_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [2:0]       op0_i,
    input  logic [2:0]       op1_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             done0_o,
    output logic             done1_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zf_o,
    output logic             of_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_f_i,
    input  logic             alu_zf_i,
    input  logic             alu_of_i,
    output logic             busy_o
);

    typedef enum logic {StIdle, StExec} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             win_q, win_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zf_q, zf_d, of_q, of_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             win_sel;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        result_d = result_q;
        zf_d     = zf_q;
        of_d     = of_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        win_sel  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req0_i || req1_i) begin
                    // On a tie the requester that did not win last time goes next.
                    win_sel  = (req0_i && req1_i) ? ~last_q : req1_i;
                    alu_op_d = win_sel ? op1_i : op0_i;
                    alu_a_d  = win_sel ? a1_i : a0_i;
                    alu_b_d  = win_sel ? b1_i : b0_i;
                    gnt0_d   = ~win_sel;
                    gnt1_d   = win_sel;
                    last_d   = win_sel;
                    win_d    = win_sel;
                    state_d  = StExec;
                end
            end
            StExec: begin
                result_d = alu_f_i;
                zf_d     = alu_zf_i;
                of_d     = alu_of_i;
                done0_d  = ~win_q;
                done1_d  = win_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            zf_q     <= 1'b0;
            of_q     <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            of_q     <= of_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign gnt0_o   = gnt0_q;
    assign gnt1_o   = gnt1_q;
    assign done0_o  = done0_q;
    assign done1_o  = done1_q;
    assign result_o = result_q;
    assign zf_o     = zf_q;
    assign of_o     = of_q;
    assign alu_a_o  = alu_a_q;
    assign alu_b_o  = alu_b_q;
    assign alu_op_o = alu_op_q;
    assign busy_o   = (state_q == StExec);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: directed scenarios plus randomized traffic against a
// cycle-level arbitration model; a small behavioural ALU sits on the ALU port.
module tb_alu_arbiter_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [2:0]   op0 = '0, op1 = '0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, done0, done1, zf, of, busy;
    logic [W-1:0] result, alu_a, alu_b, alu_f;
    logic [2:0]   alu_op;
    logic         alu_zf, alu_of;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0_i   (req0),
        .req1_i   (req1),
        .op0_i    (op0),
        .op1_i    (op1),
        .a0_i     (a0),
        .b0_i     (b0),
        .a1_i     (a1),
        .b1_i     (b1),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1),
        .done0_o  (done0),
        .done1_o  (done1),
        .result_o (result),
        .zf_o     (zf),
        .of_o     (of),
        .alu_a_o  (alu_a),
        .alu_b_o  (alu_b),
        .alu_op_o (alu_op),
        .alu_f_i  (alu_f),
        .alu_zf_i (alu_zf),
        .alu_of_i (alu_of),
        .busy_o   (busy)
    );

    // Returns {of, zf, f}; opcode 7 forces F=0 with both flags set.
    function automatic logic [W+1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] f;
        logic         ovf;
        f   = '0;
        ovf = 1'b0;
        case (op)
            3'd0: begin f = a + b; ovf = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]); end
            3'd1: begin f = a - b; ovf = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]); end
            3'd2: f = a & b;
            3'd3: f = a ^ b;
            3'd7: return {1'b1, 1'b1, {W{1'b0}}};
            default: f = a | b;
        endcase
        return {ovf, (f == '0), f};
    endfunction

    always_comb {alu_of, alu_zf, alu_f} = ref_alu(alu_op, alu_a, alu_b);

    task automatic apply_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        req0 = 1'b1; op0 = 3'd3; a0 = 16'h1234; b0 = 16'h00ff;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt0, gnt1, done0, done1, busy, zf, of} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {gnt0, gnt1, done0, done1, busy, zf, of});
        end
        n_checks++;
        if ({result, alu_a, alu_b, alu_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h alu_a=%h alu_b=%h alu_op=%h expected all 0",
                     result, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req0 = 1'b1; op0 = 3'd0; a0 = 16'd5; b0 = 16'd3;
        @(posedge clk); #1;
        n_checks++;
        if ({gnt0, gnt1, done0, done1, busy, alu_a, alu_b, alu_op} !==
            {5'b10001, 16'd5, 16'd3, 3'd0}) begin
            n_fail++;
            $display("FAIL single_grant: gnt0=%b gnt1=%b done=%b%b busy=%b a=%0d b=%0d op=%0d expected gnt0=1 busy=1 a=5 b=3 op=0",
                     gnt0, gnt1, done0, done1, busy, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({gnt0, gnt1, done0, done1, busy, result, zf, of} !== {5'b00100, 16'd8, 2'b00}) begin
            n_fail++;
            $display("FAIL single_done: gnt=%b%b done=%b%b busy=%b result=%0d zf=%b of=%b expected done0=1 result=8 zf=0 of=0",
                     gnt0, gnt1, done0, done1, busy, result, zf, of);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done0, done1, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_done_pulse: done0=%b done1=%b busy=%b expected 000", done0, done1, busy);
        end
    endtask

    task automatic test_tie();
        logic [3:0] exp_pat [6];
        exp_pat = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
        apply_reset();
        req0 = 1'b1; op0 = 3'd2; a0 = 16'hf0f0; b0 = 16'h0ff0;
        req1 = 1'b1; op1 = 3'd1; a1 = 16'd100; b1 = 16'd1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin req0 = 1'b0; req1 = 1'b0; end
            n_checks++;
            if ({gnt0, gnt1, done0, done1} !== exp_pat[c]) begin
                n_fail++;
                $display("FAIL tie_cycle%0d: gnt0 gnt1 done0 done1=%b expected %b",
                         c, {gnt0, gnt1, done0, done1}, exp_pat[c]);
            end
        end
    endtask

    task automatic test_lone();
        @(negedge clk);
        req1 = 1'b1; op1 = 3'd0; a1 = 16'd7; b1 = 16'd9;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 4) req1 = 1'b0;
            n_checks++;
            if ({gnt0, gnt1, done0, done1} !== ((c % 2 == 0) ? 4'b0100 : 4'b0001)) begin
                n_fail++;
                $display("FAIL lone_cycle%0d: gnt0 gnt1 done0 done1=%b expected %b",
                         c, {gnt0, gnt1, done0, done1}, (c % 2 == 0) ? 4'b0100 : 4'b0001);
            end
        end
        n_checks++;
        if (result !== 16'd16) begin
            n_fail++;
            $display("FAIL lone_result: got %0d expected 16", result);
        end
    endtask

    task automatic test_flags();
        @(negedge clk);
        req0 = 1'b1; op0 = 3'd7; a0 = 16'h8000; b0 = 16'h8000;
        @(posedge clk); #1;
        req0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({result, zf, of} !== {16'd0, 2'b11}) begin
                n_fail++;
                $display("FAIL flags_cycle%0d: result=%h zf=%b of=%b expected result=0 zf=1 of=1",
                         c, result, zf, of);
            end
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        req0 = 1'b1; op0 = 3'd0; a0 = 16'd1; b0 = 16'd1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy: got %b expected 1", busy);
        end
        #2;
        rst_n = 1'b0;
        req0  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({done0, done1, busy, result} !== {3'b000, 16'd0}) begin
                n_fail++;
                $display("FAIL abort_cycle%0d: done0=%b done1=%b busy=%b result=%h expected all 0",
                         c, done0, done1, busy, result);
            end
        end
    endtask

    task automatic test_random();
        logic         pend [2];
        logic [2:0]   pop [2];
        logic [W-1:0] pa [2];
        logic [W-1:0] pb [2];
        logic         last = 1'b1, in_flight = 1'b0, owner = 1'b0, w = 1'b0;
        logic [1:0]   e_gnt, e_done;
        logic [W+1:0] r;
        logic [W-1:0] e_res = '0, e_a = '0, e_b = '0;
        logic [2:0]   e_op = '0;
        logic         e_zf = 1'b0, e_of = 1'b0;
        pend = '{1'b0, 1'b0};
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pop[i]  = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
                    pa[i]   = W'($urandom);
                    pb[i]   = ($urandom_range(0, 7) == 0) ? -pa[i] : W'($urandom);
                end
            end
            req0 = pend[0]; op0 = pop[0]; a0 = pa[0]; b0 = pb[0];
            req1 = pend[1]; op1 = pop[1]; a1 = pa[1]; b1 = pb[1];
            // Completion of the previous grant, then arbitration only if no op is in flight.
            e_done = 2'b00;
            if (in_flight) begin
                e_done[owner] = 1'b1;
                r = ref_alu(e_op, e_a, e_b);
                {e_of, e_zf, e_res} = r;
            end
            e_gnt = 2'b00;
            if (!in_flight && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? ~last : pend[1];
                e_gnt[w] = 1'b1;
                e_op = pop[w]; e_a = pa[w]; e_b = pb[w];
                last = w;
            end
            @(posedge clk); #1;
            n_checks++;
            if ({gnt1, gnt0} !== e_gnt) begin
                n_fail++;
                $display("FAIL rand_gnt c=%0d: gnt1gnt0=%b expected %b", c, {gnt1, gnt0}, e_gnt);
            end
            n_checks++;
            if ({done1, done0} !== e_done) begin
                n_fail++;
                $display("FAIL rand_done c=%0d: done1done0=%b expected %b", c, {done1, done0}, e_done);
            end
            n_checks++;
            if (busy !== (e_gnt != 2'b00)) begin
                n_fail++;
                $display("FAIL rand_busy c=%0d: got %b expected %b", c, busy, (e_gnt != 2'b00));
            end
            n_checks++;
            if ({result, zf, of} !== {e_res, e_zf, e_of}) begin
                n_fail++;
                $display("FAIL rand_result c=%0d: result=%h zf=%b of=%b expected result=%h zf=%b of=%b",
                         c, result, zf, of, e_res, e_zf, e_of);
            end
            n_checks++;
            if ({alu_op, alu_a, alu_b} !== {e_op, e_a, e_b}) begin
                n_fail++;
                $display("FAIL rand_alu_regs c=%0d: op=%0d a=%h b=%h expected op=%0d a=%h b=%h",
                         c, alu_op, alu_a, alu_b, e_op, e_a, e_b);
            end
            if (e_gnt != 2'b00) pend[w] = 1'b0;
            in_flight = (e_gnt != 2'b00);
            owner     = w;
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_lone();
        test_flags();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
